cfu_req_adapter: RTL and testbench

//  Upstream front-end for the CFU MAC/quantise unit: takes custom-instruction commands from the CPU,

---
 rtl/cfu_req_adapter_pkg.sv | 26 ++
 rtl/cfu_req_adapter_if.sv | 33 +++
 rtl/cfu_req_adapter_cmd_fifo.sv | 71 +++++++
 rtl/cfu_req_adapter.sv | 157 +++++++++++++++
 tb/tb_cfu_req_adapter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfu_req_adapter_pkg.sv
// Shared types for the CFU request adapter: CFU opcodes, FSM states and a
// saturating counter helper.
package cfu_req_adapter_pkg;

  typedef enum logic [2:0] {
    OP_BIGSUM    = 3'd0,
    OP_SMALLSUM  = 3'd1,
    OP_BIAS      = 3'd2,
    OP_BIAS_RELU = 3'd3,
    OP_CYCLES    = 3'd4,
    OP_TOTAL     = 3'd5,
    OP_CPU       = 3'd6,
    OP_RW        = 3'd7
  } cfu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } cfu_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/cfu_req_adapter_if.sv
// CPU command/response and CFU request bundle. The adapter takes the slave
// view; the CPU/CFU environment takes the master view.
interface cfu_req_adapter_if #(parameter int WIDTH = 32);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_rs1;
  logic [WIDTH-1:0] cmd_rs2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             cfu_valid;
  logic [2:0]       cfu_op;
  logic [WIDTH-1:0] cfu_rs1;
  logic [WIDTH-1:0] cfu_rs2;
  logic             cfu_ready;
  logic [WIDTH-1:0] cfu_rd;
  logic             busy;
  logic [15:0]      timeout_cnt;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, rsp_ready, cfu_ready, cfu_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, cfu_valid, cfu_op, cfu_rs1,
           cfu_rs2, busy, timeout_cnt
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, rsp_ready, cfu_ready, cfu_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, cfu_valid, cfu_op, cfu_rs1,
           cfu_rs2, busy, timeout_cnt
  );
endinterface

// File: rtl/cfu_req_adapter_cmd_fifo.sv
// Synchronous command FIFO. Flags are registered, so a pushed entry becomes
// visible the cycle after the push and o_ready never reflects a same-cycle pop.
module cfu_cmd_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          ready_q, ready_d;
  logic          push_s, pop_s;

  // Pointer, occupancy and flag next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_s   = i_push && ready_q;
    pop_s    = i_pop && !empty_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d   = cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    empty_d = (cnt_d == (AW+1)'(0));
    ready_d = (cnt_d != (AW+1)'(DEPTH));
  end

  // State registers; storage needs no reset since empty_q guards reads.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
    if (i_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_empty = empty_q;
  assign o_ready = ready_q;
endmodule

// File: rtl/cfu_req_adapter.sv
// CPU-to-CFU request adapter: buffers commands, drives the CFU level
// valid/ready protocol with a mandatory valid-low gap, and times out a stuck CFU.
module cfu_req_adapter
  import cfu_req_adapter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  cfu_req_adapter_if.slave bus
);
  localparam int FW = 3 + 2 * WIDTH;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [FW-1:0] fifo_data_s;
  logic          fifo_empty_s;
  logic          fifo_ready_s;
  logic          pop_s;

  cfu_state_e       state_q, state_d;
  logic             cfu_valid_q, cfu_valid_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      tcnt_q, tcnt_d;

  cfu_cmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.cmd_valid),
    .i_data  ({bus.cmd_op, bus.cmd_rs1, bus.cmd_rs2}),
    .i_pop   (pop_s),
    .o_data  (fifo_data_s),
    .o_empty (fifo_empty_s),
    .o_ready (fifo_ready_s)
  );

  // FSM next-state; issuing pops the FIFO head into the CFU operand registers.
  always_comb begin
    state_d     = state_q;
    cfu_valid_d = cfu_valid_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_d     = ST_ISSUE;
          cfu_valid_d = 1'b1;
          op_d        = fifo_data_s[FW-1 -: 3];
          rs1_d       = fifo_data_s[2*WIDTH-1 -: WIDTH];
          rs2_d       = fifo_data_s[WIDTH-1:0];
          timer_d     = {TW{1'b0}};
        end else begin
          cfu_valid_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        // Ready is checked first so a response on the last allowed cycle is not an error.
        if (bus.cfu_ready) begin
          state_d     = ST_RESP;
          cfu_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.cfu_rd;
          rsp_err_d   = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = ST_RESP;
          cfu_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {WIDTH{1'b0}};
          rsp_err_d   = 1'b1;
          tcnt_d      = sat_inc16(tcnt_q);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            state_d     = ST_ISSUE;
            cfu_valid_d = 1'b1;
            op_d        = fifo_data_s[FW-1 -: 3];
            rs1_d       = fifo_data_s[2*WIDTH-1 -: WIDTH];
            rs2_d       = fifo_data_s[WIDTH-1:0];
            timer_d     = {TW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cfu_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cfu_valid_q <= 1'b0;
      op_q        <= 3'd0;
      rs1_q       <= {WIDTH{1'b0}};
      rs2_q       <= {WIDTH{1'b0}};
      timer_q     <= {TW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
      tcnt_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cfu_valid_q <= cfu_valid_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.cmd_ready   = fifo_ready_s;
  assign bus.cfu_valid   = cfu_valid_q;
  assign bus.cfu_op      = op_q;
  assign bus.cfu_rs1     = rs1_q;
  assign bus.cfu_rs2     = rs2_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.timeout_cnt = tcnt_q;
  assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty_s;
endmodule

// File: tb/tb_cfu_req_adapter.sv
// Bench for cfu_req_adapter: behavioural CFU plus a transaction-level scoreboard
// checked every cycle, with directed scenarios and hand-computed pins.
module tb_cfu_req_adapter;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;

  cfu_req_adapter_if #(.WIDTH(W)) bus();
  cfu_req_adapter #(.WIDTH(W), .FIFO_DEPTH(2), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] cfu_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = 32'd0;
    if (op == 3'd0) begin
      for (int i = 0; i < 4; i++) s = s + 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
    end else begin
      s = (a ^ b) + {29'd0, op};
    end
    return s;
  endfunction

  // Behavioural CFU: ready once valid has been high for cfu_delay cycles.
  int   cfu_delay = 2;
  int   vcnt = 0;
  logic ready_pulse = 1'b0;
  always @(posedge clk) begin
    vcnt  <= bus.cfu_valid ? vcnt + 1 : 0;
    cyc   <= cyc + 1;
    rst_s <= rst;
  end
  assign bus.cfu_ready = (bus.cfu_valid && (vcnt >= cfu_delay)) || ready_pulse;
  assign bus.cfu_rd    = cfu_result(bus.cfu_op, bus.cfu_rs1, bus.cfu_rs2);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] data;
    logic        err;
    logic [7:0]  exp_hi;
  } exp_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t        pend_q[$];
  exp_t        fly_q[$];
  int          hs_cyc[$];
  logic [31:0] hs_data[$];
  int          rise_cyc[$];
  int          fifo_cnt = 0;
  int          hi_cnt = 0;
  int          n_hs = 0;
  int          t_acc = 0;
  int          t_rsp_rise = 0;
  int          nready_cyc = 0;
  logic [15:0] model_tcnt = 16'd0;
  logic [31:0] last_data;
  logic        last_err;
  logic [15:0] last_tcnt;
  logic        prev_cv = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_data = 32'd0, prev_rs1 = 32'd0, prev_rs2 = 32'd0;
  logic [2:0]  prev_op = 3'd0;

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    exp_t e;
    if (rst_s) begin
      chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
      chk("rst_cfu_valid", bus.cfu_valid, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_timeout_cnt", bus.timeout_cnt, 16'd0);
      pend_q.delete();
      fly_q.delete();
      fifo_cnt   = 0;
      hi_cnt     = 0;
      model_tcnt = 16'd0;
      prev_cv    = 1'b0;
      prev_rv    = 1'b0;
      prev_rr    = 1'b0;
    end else begin
      if (bus.cfu_valid && !prev_cv) begin
        fifo_cnt--;
        rise_cyc.push_back(cyc);
        hi_cnt = 0;
        chk("issue_pending", pend_q.size() > 0, 1'b1);
        if (pend_q.size() > 0) begin
          e = pend_q.pop_front();
          chk("issue_ops", {bus.cfu_op, bus.cfu_rs1, bus.cfu_rs2}, {e.op, e.rs1, e.rs2});
          fly_q.push_back(e);
        end
      end
      if (bus.cfu_valid) hi_cnt++;
      if (bus.cfu_valid && prev_cv)
        chk("ops_stable", {bus.cfu_op, bus.cfu_rs1, bus.cfu_rs2}, {prev_op, prev_rs1, prev_rs2});
      if (!bus.cfu_valid && prev_cv) begin
        chk("resp_after_issue", bus.rsp_valid, 1'b1);
        if (fly_q.size() > 0) chk("valid_cycles", hi_cnt, fly_q[0].exp_hi);
      end
      if (!bus.cmd_ready) nready_cyc++;
      chk("cmd_ready", bus.cmd_ready, fifo_cnt < 2);
      chk("busy", bus.busy, bus.cfu_valid || bus.rsp_valid || (fifo_cnt > 0));
      chk("valid_gap", bus.cfu_valid && bus.rsp_valid, 1'b0);
      if (bus.rsp_valid && prev_rv && !prev_rr)
        chk("rsp_hold", {bus.rsp_data, bus.rsp_err}, {prev_data, prev_err});
      if (bus.rsp_valid && !prev_rv) t_rsp_rise = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", fly_q.size() > 0, 1'b1);
        if (fly_q.size() > 0) begin
          e = fly_q.pop_front();
          if (e.err && model_tcnt != 16'hFFFF) model_tcnt = model_tcnt + 16'd1;
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("timeout_cnt", bus.timeout_cnt, model_tcnt);
        end
        last_data = bus.rsp_data;
        last_err  = bus.rsp_err;
        last_tcnt = bus.timeout_cnt;
        hs_cyc.push_back(cyc);
        hs_data.push_back(bus.rsp_data);
        n_hs++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e.op     = bus.cmd_op;
        e.rs1    = bus.cmd_rs1;
        e.rs2    = bus.cmd_rs2;
        e.err    = (cfu_delay >= TO);
        e.data   = e.err ? 32'd0 : cfu_result(bus.cmd_op, bus.cmd_rs1, bus.cmd_rs2);
        e.exp_hi = e.err ? 8'(TO) : 8'(cfu_delay + 1);
        pend_q.push_back(e);
        fifo_cnt++;
        t_acc = cyc;
      end
      prev_cv   = bus.cfu_valid;
      prev_rv   = bus.rsp_valid;
      prev_rr   = bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_err  = bus.rsp_err;
      prev_op   = bus.cfu_op;
      prev_rs1  = bus.cfu_rs1;
      prev_rs2  = bus.cfu_rs2;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int   t;
    logic got;
    t   = 0;
    got = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rs1   = a;
    bus.cmd_rs2   = b;
    while (!got && t < 200) begin
      @(negedge clk);
      got = bus.cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.cmd_valid = 1'b0;
    chk("send_accepted", got, 1'b1);
  endtask

  task automatic wait_hs(input int n);
    int t;
    t = 0;
    while (n_hs < n && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_hs_bound", n_hs >= n, 1'b1);
  endtask

  task automatic wait_rsp_valid();
    int t;
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_rsp_valid_bound", bus.rsp_valid, 1'b1);
  endtask

  initial begin
    int n0, r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rs1   = 32'd0;
    bus.cmd_rs2   = 32'd0;
    bus.rsp_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);

    // 1: single command, latency and bigsum result 2*0x21.
    send(3'd0, 32'h0003_0200, 32'h0000_2100);
    wait_hs(1);
    chk("t1_data", last_data, 32'h0000_0042);
    chk("t1_err", last_err, 1'b0);
    chk("t1_valid_latency", rise_cyc[0] - t_acc, 2);
    chk("t1_rsp_latency", t_rsp_rise - t_acc, 5);
    idle(3);

    // 2: three back-to-back commands.
    n0 = n_hs;
    nready_cyc = 0;
    send(3'd1, 32'h0000_0011, 32'h0000_0022);
    send(3'd0, 32'h0101_0101, 32'h0202_0202);
    send(3'd2, 32'h0000_0010, 32'h0000_0001);
    wait_hs(n0 + 3);
    chk("t2_first", hs_data[n0], 32'h0000_0034);
    chk("t2_second", hs_data[n0 + 1], 32'h0000_0008);
    chk("t2_third", hs_data[n0 + 2], 32'h0000_0013);
    chk("t2_throughput", hs_cyc[n0 + 2] - hs_cyc[n0 + 1], 4);
    chk("t2_fifo_full_seen", nready_cyc > 0, 1'b1);
    idle(3);

    // 3: response back-pressure for 10 cycles.
    n0 = n_hs;
    r0 = rise_cyc.size();
    bus.rsp_ready = 1'b0;
    send(3'd3, 32'h0000_1234, 32'h0000_00FF);
    send(3'd4, 32'h0000_0005, 32'h0000_0003);
    wait_rsp_valid();
    idle(10);
    chk("t3_held_valid", bus.rsp_valid, 1'b1);
    chk("t3_cfu_idle", bus.cfu_valid, 1'b0);
    chk("t3_no_second_issue", rise_cyc.size(), r0 + 1);
    bus.rsp_ready = 1'b1;
    wait_hs(n0 + 2);
    chk("t3_issue_after_accept", rise_cyc[r0 + 1] - hs_cyc[n0], 1);
    idle(3);

    // 4: stalled CFU times out, then ready exactly on the last cycle wins.
    n0 = n_hs;
    cfu_delay = 8;
    send(3'd5, 32'h0000_00AA, 32'h0000_0055);
    wait_hs(n0 + 1);
    chk("t4_err", last_err, 1'b1);
    chk("t4_data", last_data, 32'd0);
    chk("t4_tcnt", last_tcnt, 16'd1);
    cfu_delay = 2;
    send(3'd6, 32'h0000_0F00, 32'h0000_00F0);
    wait_hs(n0 + 2);
    chk("t4_recover_err", last_err, 1'b0);
    chk("t4_recover_data", last_data, 32'h0000_0FF6);
    cfu_delay = 7;
    send(3'd7, 32'h0000_0001, 32'h0000_0001);
    wait_hs(n0 + 3);
    chk("t4_ready_wins_err", last_err, 1'b0);
    chk("t4_ready_wins_data", last_data, 32'h0000_0007);
    chk("t4_ready_wins_tcnt", last_tcnt, 16'd1);
    cfu_delay = 2;
    idle(3);

    // 5: reset mid-ISSUE with one command still buffered.
    cfu_delay = 8;
    send(3'd1, 32'h0000_0100, 32'h0000_0200);
    send(3'd2, 32'h0000_0300, 32'h0000_0400);
    idle(2);
    chk("t5_in_issue", bus.cfu_valid, 1'b1);
    n0 = n_hs;
    r0 = rise_cyc.size();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("t5_cfu_valid", bus.cfu_valid, 1'b0);
    chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    idle(20);
    chk("t5_no_stale_rsp", n_hs, n0);
    chk("t5_no_stale_issue", rise_cyc.size(), r0);
    cfu_delay = 2;
    send(3'd0, 32'h0000_0003, 32'h0000_0004);
    wait_hs(n0 + 1);
    chk("t5_after_reset_data", last_data, 32'h0000_000C);
    chk("t5_tcnt_cleared", last_tcnt, 16'd0);
    idle(3);

    // 6: CFU ready pulses outside ISSUE are ignored.
    n0 = n_hs;
    r0 = rise_cyc.size();
    ready_pulse = 1'b1;
    idle(1);
    ready_pulse = 1'b0;
    idle(5);
    chk("t6_idle_pulse", n_hs, n0);
    bus.rsp_ready = 1'b0;
    send(3'd4, 32'h0000_0002, 32'h0000_0008);
    wait_rsp_valid();
    ready_pulse = 1'b1;
    idle(1);
    ready_pulse = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_hs(n0 + 1);
    idle(10);
    chk("t6_resp_pulse", n_hs, n0 + 1);
    chk("t6_single_issue", rise_cyc.size(), r0 + 1);
    chk("t6_data", last_data, 32'h0000_000E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
